// File: rtl/pipe_regs_pkg.sv
// Shared constants and helpers for the pipe_regs register pipeline.
// Holds the parameter defaults, the bubble (nop) payload and the per-rank action decision.
package pipe_regs_pkg;

  localparam int unsigned STAGES_DEF = 4;
  localparam int unsigned DW_DEF     = 193;
  localparam int unsigned CW_DEF     = 16;

  // Widest payload any rank may carry; bubbles take the low DW bits of NOP_WORD.
  localparam int unsigned DW_MAX = 1024;
  localparam logic [DW_MAX-1:0] NOP_WORD = '0;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_KEEP   = 2'd1,
    ACT_BUBBLE = 2'd2
  } rank_act_e;

  // Flush beats hold, hold beats an upstream freeze, otherwise the rank advances.
  function automatic rank_act_e rank_action(input logic flush,
                                            input logic frozen,
                                            input logic kill);
    rank_action = ACT_LOAD;
    if (flush) begin
      rank_action = ACT_BUBBLE;
    end else if (frozen) begin
      rank_action = ACT_KEEP;
    end else if (kill) begin
      rank_action = ACT_BUBBLE;
    end
  endfunction

endpackage

// File: rtl/pipe_regs_if.sv
// Bus bundle between the pipeline and its source/consumers.
// Handshake: rank 0 captures in_data/in_valid on a rising edge only while in_ready=1;
// when in_ready=0 the input is ignored and the source must keep presenting it.
interface pipe_regs_if
  import pipe_regs_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int DW     = DW_DEF
);

  logic [DW-1:0]        in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [STAGES-1:0]    hold_req;
  logic [STAGES-1:0]    flush;
  logic [STAGES*DW-1:0] stage_data;
  logic [STAGES-1:0]    stage_valid;

  modport master (
    output in_data,
    output in_valid,
    output hold_req,
    output flush,
    input  in_ready,
    input  stage_data,
    input  stage_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  hold_req,
    input  flush,
    output in_ready,
    output stage_data,
    output stage_valid
  );

endinterface

// File: rtl/pipe_rank.sv
// One pipeline rank: a valid bit plus DW-bit payload register.
// Each edge it loads from upstream, keeps, or becomes a bubble, by flush/freeze priority.
module pipe_rank
  import pipe_regs_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          frozen,
  input  logic          kill,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output rank_act_e     act
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q,  data_d;

  always_comb begin
    act     = rank_action(flush, frozen, kill);
    valid_d = valid_q;
    data_d  = data_q;
    case (act)
      ACT_BUBBLE: begin
        valid_d = 1'b0;
        data_d  = NOP_WORD[DW-1:0];
      end
      ACT_KEEP: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
      default: begin
        valid_d = up_valid;
        data_d  = up_data;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/pipe_regs.sv
// STAGES-deep register pipeline with per-rank hold/flush and saturating stall/flush counters.
// A hold on rank k freezes every rank upstream of it; the rank just downstream of a freeze fills with bubbles.
module pipe_regs
  import pipe_regs_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int DW     = DW_DEF,
  parameter int CW     = CW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  pipe_regs_if.slave        bus,
  input  logic              clr_cnt,
  output logic [CW-1:0]     stall_cnt,
  output logic [CW-1:0]     flush_cnt,
  output logic [2*STAGES-1:0] rank_act
);

  logic [STAGES-1:0] frozen;
  logic              stall_inc;
  logic              flush_inc;
  logic [CW-1:0]     stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]     flush_cnt_q, flush_cnt_d;

  logic              valid_w [STAGES];
  logic [DW-1:0]     data_w  [STAGES];

  // frozen[k] is the OR of hold_req over rank k and everything downstream.
  always_comb begin
    frozen = '0;
    for (int k = 0; k < STAGES; k++) begin
      frozen[k] = |(bus.hold_req >> k);
    end
  end

  // Purely combinational so it tracks hold_req even while reset is asserted.
  assign bus.in_ready = ~frozen[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_rank
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic          kill;
    rank_act_e     act;

    if (k == 0) begin : g_head
      assign up_valid = bus.in_valid;
      assign up_data  = bus.in_data;
      assign kill     = 1'b0;
    end else begin : g_body
      assign up_valid = valid_w[k-1];
      assign up_data  = data_w[k-1];
      assign kill     = frozen[k-1];
    end

    pipe_rank #(
      .DW (DW)
    ) u_rank (
      .clk       (clk),
      .reset     (reset),
      .flush     (bus.flush[k]),
      .frozen    (frozen[k]),
      .kill      (kill),
      .up_valid  (up_valid),
      .up_data   (up_data),
      .out_valid (valid_w[k]),
      .out_data  (data_w[k]),
      .act       (act)
    );

    assign bus.stage_valid[k]         = valid_w[k];
    assign bus.stage_data[k*DW +: DW] = data_w[k];
    assign rank_act[2*k +: 2]         = act;
  end

  assign stall_inc = ~bus.in_ready;
  assign flush_inc = |bus.flush;

  // Clear wins over increment; both counters stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clr_cnt) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall_inc && (stall_cnt_q != {CW{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + CW'(1);
      end
      if (flush_inc && (flush_cnt_q != {CW{1'b1}})) begin
        flush_cnt_d = flush_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_regs.sv
// Bench for pipe_regs at STAGES=4, DW=8, CW=4: directed scenarios then random traffic,
// checked against a cycle-level model of the hold/flush/bubble rules.
module tb_pipe_regs;

  localparam int S = 4;
  localparam int W = 8;
  localparam int C = 4;
  localparam int CMAX = (1 << C) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           clr_cnt = 1'b0;
  logic [C-1:0]   stall_cnt;
  logic [C-1:0]   flush_cnt;
  logic [2*S-1:0] rank_act;

  pipe_regs_if #(.STAGES(S), .DW(W)) bus ();

  pipe_regs #(.STAGES(S), .DW(W), .CW(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .clr_cnt   (clr_cnt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt),
    .rank_act  (rank_act)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int m_v [S];
  int m_d [S];
  int m_stall;
  int m_flush;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < S; k++) begin
      chk($sformatf("%s valid%0d", tag, k), 32'(bus.stage_valid[k]), m_v[k]);
      chk($sformatf("%s data%0d", tag, k), 32'(bus.stage_data[k*W +: W]), m_d[k]);
    end
    chk({tag, " stall_cnt"}, 32'(stall_cnt), m_stall);
    chk({tag, " flush_cnt"}, 32'(flush_cnt), m_flush);
  endtask

  // A rank is stuck if any consumer at or beyond it asks for a hold.
  function automatic bit stuck(input int k, input logic [S-1:0] h);
    for (int j = k; j < S; j++) begin
      if (h[j]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < S; k++) begin
      m_v[k] = 0;
      m_d[k] = 0;
    end
    m_stall = 0;
    m_flush = 0;
  endfunction

  // Called at a falling edge; applies inputs, checks in_ready, clocks once, checks outputs.
  task automatic step(input string tag, input bit iv, input logic [W-1:0] id,
                      input logic [S-1:0] h, input logic [S-1:0] fl, input bit clr);
    int nv [S];
    int nd [S];
    bit ready;
    bus.in_valid = iv;
    bus.in_data  = id;
    bus.hold_req = h;
    bus.flush    = fl;
    clr_cnt      = clr;
    #1;
    ready = !stuck(0, h);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(ready));
    for (int k = 0; k < S; k++) begin
      if (fl[k]) begin
        nv[k] = 0; nd[k] = 0;
      end else if (stuck(k, h)) begin
        nv[k] = m_v[k]; nd[k] = m_d[k];
      end else if (k > 0 && stuck(k - 1, h)) begin
        nv[k] = 0; nd[k] = 0;
      end else if (k == 0) begin
        nv[k] = iv; nd[k] = id;
      end else begin
        nv[k] = m_v[k-1]; nd[k] = m_d[k-1];
      end
    end
    @(posedge clk);
    #1;
    m_v = nv;
    m_d = nd;
    if (clr) begin
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (!ready && m_stall < CMAX) m_stall++;
      if (fl != 0 && m_flush < CMAX) m_flush++;
    end
    check_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.hold_req = '0;
    bus.flush    = '0;
    model_reset();

    // Reset state, and in_ready following hold_req while reset is held.
    #12;
    check_outputs("reset");
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    bus.hold_req = 4'b0001;
    #1;
    chk("reset in_ready held", 32'(bus.in_ready), 32'd0);
    bus.hold_req = '0;
    @(negedge clk);
    reset = 1'b1;

    // Streaming: 0x11 reaches rank 3 after the fourth edge.
    step("stream1", 1'b1, 8'h11, 4'b0000, 4'b0000, 1'b0);
    step("stream2", 1'b1, 8'h22, 4'b0000, 4'b0000, 1'b0);
    step("stream3", 1'b1, 8'h33, 4'b0000, 4'b0000, 1'b0);
    step("stream4", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
    chk("stream rank3", 32'(bus.stage_data[3*W +: W]), 32'h11);
    chk("stream rank3 valid", 32'(bus.stage_valid[3]), 32'd1);

    // Load-use stall with 0x22 sitting in rank 1.
    step("lu_fill1", 1'b1, 8'h11, 4'b0000, 4'b0000, 1'b0);
    step("lu_fill2", 1'b1, 8'h22, 4'b0000, 4'b0000, 1'b0);
    step("lu_fill3", 1'b1, 8'h33, 4'b0000, 4'b0000, 1'b0);
    step("lu_hold", 1'b1, 8'h44, 4'b0010, 4'b0000, 1'b0);
    chk("lu rank1 kept", 32'(bus.stage_data[1*W +: W]), 32'h22);
    chk("lu rank2 bubble", 32'(bus.stage_data[2*W +: W]), 32'h00);
    chk("lu rank2 invalid", 32'(bus.stage_valid[2]), 32'd0);
    chk("lu stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch flush on ranks 0-1 with a hold on rank 2.
    step("br", 1'b1, 8'h44, 4'b0100, 4'b0011, 1'b0);
    chk("br rank0 invalid", 32'(bus.stage_valid[0]), 32'd0);
    chk("br rank3 invalid", 32'(bus.stage_valid[3]), 32'd0);
    chk("br flush_cnt", 32'(flush_cnt), 32'd1);

    // Saturation, then clear taking priority over a still-active stall.
    for (int i = 0; i < 20; i++) begin
      step("sat", 1'b1, 8'h55, 4'b1000, 4'b0000, 1'b0);
    end
    chk("sat stall_cnt", 32'(stall_cnt), 32'hF);
    step("clr", 1'b1, 8'h55, 4'b1000, 4'b0000, 1'b1);
    chk("clr stall_cnt", 32'(stall_cnt), 32'h0);

    // Asynchronous reset between edges with every rank full.
    for (int i = 0; i < S; i++) begin
      step("rst_fill", 1'b1, 8'(8'hA0 + i), 4'b0000, 4'b0000, 1'b0);
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    reset = 1'b1;
    step("post_rst0", 1'b1, 8'h44, 4'b0000, 4'b0000, 1'b0);
    for (int i = 1; i < S; i++) begin
      step("post_rst", 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
    end
    chk("post_rst rank3", 32'(bus.stage_data[3*W +: W]), 32'h44);

    // Random traffic with sparse holds, flushes and clears.
    for (int i = 0; i < 300; i++) begin
      logic [S-1:0] h;
      logic [S-1:0] fl;
      h  = ($urandom_range(0, 2) == 0) ? S'($urandom_range(0, 15)) : '0;
      fl = ($urandom_range(0, 3) == 0) ? S'($urandom_range(0, 15)) : '0;
      step("rand", 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), h, fl,
           ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_regs.md
PIPE_REGS -- requirements
Module: pipe_regs

Interface
REQ-001 SHALL have parameter STAGES, default 4, meaning the number of pipeline register ranks (legal range 2..8).
REQ-002 SHALL have parameter DW, default 193, meaning the payload width of every rank.
REQ-003 SHALL have parameter CW, default 16, meaning the width of each performance counter.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port in_data  input  DW  payload entering rank 0.
REQ-007 SHALL have port in_valid  input  1  in_data is a real instruction, not a bubble.
REQ-008 SHALL have port in_ready  output  1  rank 0 accepts new input this cycle.
REQ-009 SHALL have port hold_req  input  STAGES  bit k = consumer of rank k requires rank k to keep its contents.
REQ-010 SHALL have port flush  input  STAGES  bit k = kill rank k contents (e.g. branch taken).
REQ-011 SHALL have port stage_data  output  STAGES*DW  rank k contents at bits [k*DW +: DW].
REQ-012 SHALL have port stage_valid  output  STAGES  rank k holds a real instruction.
REQ-013 SHALL have port clr_cnt  input  1  synchronous clear of both counters.
REQ-014 SHALL have port stall_cnt  output  CW  cycles with in_ready low.
REQ-015 SHALL have port flush_cnt  output  CW  cycles with any flush bit high.

Function
REQ-016 SHALL define frozen[k] = OR of hold_req[k..STAGES-1], combinationally; stalls propagate upstream.
REQ-017 SHALL drive in_ready = ~frozen[0], combinationally, with no register delay.
REQ-018 SHALL, per rank k and per cycle, take the first matching action in this priority order: flush[k] -> load bubble; frozen[k] -> keep; k>0 and frozen[k-1] -> load bubble; else load from rank k-1 (rank 0 loads in_data/in_valid).
REQ-019 SHALL encode a bubble as valid=0 and data=0 (the all-zero payload is the nop encoding).
REQ-020 SHALL make rank 0 load in_valid=0 or in_data unchanged per REQ-018; input presented while in_ready=0 SHALL be ignored (the source re-presents it).
REQ-021 SHALL give each rank a latency of exactly one cycle when not frozen; stage_data/stage_valid SHALL come directly from registers.
REQ-022 SHALL let flush override hold on the same rank in the same cycle; a flushed frozen rank becomes a frozen bubble.
REQ-023 SHALL treat hold_req as valid regardless of stage_valid of that rank.
REQ-024 SHALL make simultaneous flush on ranks 0..j plus hold on rank m>j flush ranks 0..j and hold ranks j+1..m.
REQ-025 SHALL increment stall_cnt every cycle in_ready=0, and flush_cnt every cycle |flush=1; both SHALL saturate at 2^CW-1 and not wrap.
REQ-026 SHALL give clr_cnt priority over increment: the counter reads 0 on the following cycle.

Reset
REQ-027 SHALL, while reset=0, asynchronously force all stage_data=0, stage_valid=0, stall_cnt=0, flush_cnt=0.
REQ-028 SHALL discard any in-flight contents on reset mid-operation; after deassertion the first edge behaves per REQ-018 with all ranks empty.
REQ-029 SHALL derive in_ready from inputs only, so it follows hold_req even during reset.

Structure
REQ-030 SHALL place the STAGES/DW/CW defaults and the bubble (nop) encoding constant in the shared cpu package.
REQ-031 SHALL implement one sub-module, pipe_rank (a single DW-wide valid+data register with the REQ-018 priority), instantiated STAGES times via generate.
REQ-032 SHALL keep the counters in the top level; no other sub-modules.

Verification (STAGES=4, DW=8, CW=4)
REQ-033 SHALL cover streaming: in_data=0x11,0x22,0x33 valid, no hold/flush -> 0x11 appears on rank 3 on cycle 4, one value per cycle, in_ready=1 throughout.
REQ-034 SHALL cover a load-use stall: hold_req=4'b0010 for 1 cycle with 0x22 in rank 1 -> ranks 0-1 keep, rank 2 shows bubble (valid=0, data=0x00), in_ready=0, stall_cnt=1.
REQ-035 SHALL cover a branch flush: flush=4'b0011 together with hold_req=4'b0100 -> ranks 0,1 become bubbles, rank 2 holds, rank 3 bubble, flush_cnt=1.
REQ-036 SHALL cover saturation and clear: hold_req[3]=1 for 20 cycles -> stall_cnt stops at 0xF; then clr_cnt=1 for 1 cycle -> 0x0 next cycle.
REQ-037 SHALL cover reset mid-stream: reset=0 asynchronously between edges with ranks full -> all outputs 0 immediately; after release, 0x44 injected reaches rank 3 after 4 cycles.
